// File: rtl/axi_write_slave_controller.sv
// ----------------------------------------------------------------------------
// axi_interface_pkg
//   Shared AXI4-Lite widths and the response encoding used by the ZenithSoC
//   peripheral responders.
// ----------------------------------------------------------------------------
package axi_interface_pkg;

    localparam int AXI_ADDR_SIZE = 32;  // address width in bits
    localparam int AXI_DATA_SIZE = 4;   // data width in bytes

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_EXOKAY = 2'b01,
        AXI_SLVERR = 2'b10,
        AXI_DECERR = 2'b11
    } axi_response_t;

endpackage : axi_interface_pkg

// ----------------------------------------------------------------------------
// axi_write_slave_controller
//   AXI4-Lite write-path responder. Captures the AW and W channels
//   independently (either order, same cycle allowed), decodes the address
//   against [ADDR_LOW, ADDR_HIGH], issues a single write to a simple
//   peripheral register port and reports the outcome on the B channel.
//   Only one transaction is in flight at a time.
//
// Ports
//   clk_i            system clock, all logic on the rising edge
//   rst_i            synchronous active-high reset
//   AWADDR/AWVALID   write address from the master
//   AWREADY          address buffer empty and block idle
//   WDATA/WSTRB      write data and byte enables from the master
//   WVALID           write data valid
//   WREADY           data buffer empty and block idle
//   BRESP/BVALID     write response towards the master
//   BREADY           master accepts the response
//   write_address_o  captured address for the peripheral
//   write_data_o     captured data for the peripheral
//   write_strobe_o   captured byte enables for the peripheral
//   write_request_o  one-cycle pulse starting the peripheral write
//   write_done_i     peripheral finished the write
//   write_error_i    peripheral reports an error, qualified by write_done_i
//
// Latency (both channels handshaking in cycle 0, peripheral done at once):
//   cycle 1 request pulse, cycle 2 done sampled, cycle 3 BVALID.
// ----------------------------------------------------------------------------
module axi_write_slave_controller
    import axi_interface_pkg::*;
#(
    parameter logic [AXI_ADDR_SIZE-1:0] ADDR_LOW  = '0,
    parameter logic [AXI_ADDR_SIZE-1:0] ADDR_HIGH = 32'hFFFF_FFFF
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic [AXI_ADDR_SIZE-1:0]     AWADDR,
    input  logic                         AWVALID,
    output logic                         AWREADY,

    input  logic [AXI_DATA_SIZE*8-1:0]   WDATA,
    input  logic [AXI_DATA_SIZE-1:0]     WSTRB,
    input  logic                         WVALID,
    output logic                         WREADY,

    output axi_response_t                BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,

    output logic [AXI_ADDR_SIZE-1:0]     write_address_o,
    output logic [AXI_DATA_SIZE*8-1:0]   write_data_o,
    output logic [AXI_DATA_SIZE-1:0]     write_strobe_o,
    output logic                         write_request_o,
    input  logic                         write_done_i,
    input  logic                         write_error_i
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RESPOND
    } state_t;

    state_t                       state;

    logic                         aw_full;
    logic                         w_full;
    logic [AXI_ADDR_SIZE-1:0]     address_q;
    logic [AXI_DATA_SIZE*8-1:0]   data_q;
    logic [AXI_DATA_SIZE-1:0]     strobe_q;

    logic                         bvalid_q;
    axi_response_t                bresp_q;

    // Cleared by reset and set on the first clock after it, so the READYs are
    // held low for the whole time reset is applied without looking at rst_i
    // combinationally.
    logic                         accept_enable;

    logic                         aw_handshake;
    logic                         w_handshake;
    logic                         request_pending;
    logic                         above_low;
    logic                         below_high;
    logic                         in_range;
    logic                         strobe_any;

    // ------------------------------------------------------------------------
    // Address window decode. An open bound (0 or all ones) is never compared,
    // which keeps the default full-range window free of constant comparisons.
    // ------------------------------------------------------------------------
    if (ADDR_LOW == '0) begin : g_low_open
        assign above_low = 1'b1;
    end else begin : g_low_cmp
        assign above_low = (address_q >= ADDR_LOW);
    end

    if (ADDR_HIGH == '1) begin : g_high_open
        assign below_high = 1'b1;
    end else begin : g_high_cmp
        assign below_high = (address_q <= ADDR_HIGH);
    end

    assign in_range   = above_low & below_high;
    assign strobe_any = |strobe_q;

    // ------------------------------------------------------------------------
    // Channel readiness depends only on registered state, never on VALID.
    // ------------------------------------------------------------------------
    assign AWREADY = accept_enable & (state == IDLE) & ~aw_full;
    assign WREADY  = accept_enable & (state == IDLE) & ~w_full;

    assign aw_handshake = AWVALID & AWREADY;
    assign w_handshake  = WVALID & WREADY;

    // Both buffers hold a request and the block has not acted on it yet.
    assign request_pending = (state == IDLE) & aw_full & w_full;

    // The pulse is decoded from registered state only; the FSM leaves IDLE on
    // the same edge, so it lasts exactly one cycle.
    assign write_request_o = request_pending & in_range & strobe_any;

    assign write_address_o = address_q;
    assign write_data_o    = data_q;
    assign write_strobe_o  = strobe_q;

    assign BVALID = bvalid_q;
    assign BRESP  = bresp_q;

    // ------------------------------------------------------------------------
    // Capture buffers and the IDLE -> WRITE -> RESPOND sequencer.
    // The buffers can only be written in IDLE (READY is low elsewhere), and
    // they are only emptied by the B handshake in RESPOND, so capture and
    // release never collide on the same edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            accept_enable <= 1'b0;
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            address_q     <= '0;
            data_q        <= '0;
            strobe_q      <= '0;
            bvalid_q      <= 1'b0;
            bresp_q       <= AXI_OKAY;
        end else begin
            accept_enable <= 1'b1;

            if (aw_handshake) begin
                address_q <= AWADDR;
                aw_full   <= 1'b1;
            end

            if (w_handshake) begin
                data_q   <= WDATA;
                strobe_q <= WSTRB;
                w_full   <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (request_pending) begin
                        if (!in_range) begin
                            state    <= RESPOND;
                            bvalid_q <= 1'b1;
                            bresp_q  <= AXI_DECERR;
                        end else if (!strobe_any) begin
                            // Nothing to write: acknowledge without touching
                            // the peripheral.
                            state    <= RESPOND;
                            bvalid_q <= 1'b1;
                            bresp_q  <= AXI_OKAY;
                        end else begin
                            state <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    // First sampled the cycle after the request pulse; the
                    // peripheral may take arbitrarily long.
                    if (write_done_i) begin
                        state    <= RESPOND;
                        bvalid_q <= 1'b1;
                        bresp_q  <= write_error_i ? AXI_SLVERR : AXI_OKAY;
                    end
                end

                RESPOND: begin
                    if (BREADY) begin
                        state    <= IDLE;
                        bvalid_q <= 1'b0;
                        aw_full  <= 1'b0;
                        w_full   <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    bvalid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule : axi_write_slave_controller

// File: tb/tb_axi_write_slave_controller.sv
// ----------------------------------------------------------------------------
// tb_axi_write_slave_controller
//   Directed bench for the AXI4-Lite write responder with a window of
//   0x1000..0x1FFF. Each step drives the master/peripheral inputs, advances
//   one clock and compares outputs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_axi_write_slave_controller;

    import axi_interface_pkg::*;

    logic                 clk_i;
    logic                 rst_i;
    logic [31:0]          AWADDR;
    logic                 AWVALID;
    logic                 AWREADY;
    logic [31:0]          WDATA;
    logic [3:0]           WSTRB;
    logic                 WVALID;
    logic                 WREADY;
    axi_response_t        BRESP;
    logic                 BVALID;
    logic                 BREADY;
    logic [31:0]          write_address_o;
    logic [31:0]          write_data_o;
    logic [3:0]           write_strobe_o;
    logic                 write_request_o;
    logic                 write_done_i;
    logic                 write_error_i;

    int checks   = 0;
    int failures = 0;

    axi_write_slave_controller #(
        .ADDR_LOW  (32'h0000_1000),
        .ADDR_HIGH (32'h0000_1FFF)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .AWADDR          (AWADDR),
        .AWVALID         (AWVALID),
        .AWREADY         (AWREADY),
        .WDATA           (WDATA),
        .WSTRB           (WSTRB),
        .WVALID          (WVALID),
        .WREADY          (WREADY),
        .BRESP           (BRESP),
        .BVALID          (BVALID),
        .BREADY          (BREADY),
        .write_address_o (write_address_o),
        .write_data_o    (write_data_o),
        .write_strobe_o  (write_strobe_o),
        .write_request_o (write_request_o),
        .write_done_i    (write_done_i),
        .write_error_i   (write_error_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic        awvalid,
                                 input logic [31:0] awaddr,
                                 input logic        wvalid,
                                 input logic [31:0] wdata,
                                 input logic [3:0]  wstrb,
                                 input logic        bready,
                                 input logic        done,
                                 input logic        err);
        AWVALID       = awvalid;
        AWADDR        = awaddr;
        WVALID        = wvalid;
        WDATA         = wdata;
        WSTRB         = wstrb;
        BREADY        = bready;
        write_done_i  = done;
        write_error_i = err;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Full transaction: AW and W together, peripheral done one cycle after
    // the request pulse, response accepted immediately.
    task automatic doWrite(input string       tag,
                           input logic [31:0] addr,
                           input logic [31:0] data,
                           input logic [3:0]  strb,
                           input logic        err,
                           input logic [1:0]  resp);
        applyStimulus(1'b1, addr, 1'b1, data, strb, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, ".awready0"}, 64'(AWREADY), 64'd1);
        checkOutput({tag, ".wready0"}, 64'(WREADY), 64'd1);
        tick();
        applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, 32'h5A5A_5A5A, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, ".request1"}, 64'(write_request_o), 64'd1);
        checkOutput({tag, ".address1"}, 64'(write_address_o), 64'(addr));
        checkOutput({tag, ".data1"}, 64'(write_data_o), 64'(data));
        checkOutput({tag, ".strobe1"}, 64'(write_strobe_o), 64'(strb));
        checkOutput({tag, ".awready1"}, 64'(AWREADY), 64'd0);
        tick();
        checkOutput({tag, ".request2"}, 64'(write_request_o), 64'd0);
        checkOutput({tag, ".bvalid2"}, 64'(BVALID), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, err);
        tick();
        checkOutput({tag, ".bvalid3"}, 64'(BVALID), 64'd1);
        checkOutput({tag, ".bresp3"}, 64'(BRESP), 64'(resp));
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput({tag, ".bvalid4"}, 64'(BVALID), 64'd0);
        checkOutput({tag, ".awready4"}, 64'(AWREADY), 64'd1);
        checkOutput({tag, ".wready4"}, 64'(WREADY), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Transaction answered without a peripheral access (decode error or
    // empty strobe): response one cycle after the buffers fill.
    task automatic doNoAccess(input string       tag,
                              input logic [31:0] addr,
                              input logic [3:0]  strb,
                              input logic [1:0]  resp);
        applyStimulus(1'b1, addr, 1'b1, 32'hCAFE_0001, strb, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, ".request1"}, 64'(write_request_o), 64'd0);
        checkOutput({tag, ".bvalid1"}, 64'(BVALID), 64'd0);
        tick();
        checkOutput({tag, ".request2"}, 64'(write_request_o), 64'd0);
        checkOutput({tag, ".bvalid2"}, 64'(BVALID), 64'd1);
        checkOutput({tag, ".bresp2"}, 64'(BRESP), 64'(resp));
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput({tag, ".bvalid3"}, 64'(BVALID), 64'd0);
        checkOutput({tag, ".awready3"}, 64'(AWREADY), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        rst_i = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset.awready", 64'(AWREADY), 64'd0);
        checkOutput("reset.wready", 64'(WREADY), 64'd0);
        checkOutput("reset.bvalid", 64'(BVALID), 64'd0);
        checkOutput("reset.bresp", 64'(BRESP), 64'd0);
        checkOutput("reset.request", 64'(write_request_o), 64'd0);
        checkOutput("reset.address", 64'(write_address_o), 64'd0);
        rst_i = 1'b0;
        tick();
        tick();

        // Same-cycle AW and W, normal write
        doWrite("same", 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b0, 2'b00);

        // W five cycles ahead of AW
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h1234_5678, 4'h3, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'hFFFF_0000, 4'hC, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("wfirst.wready", 64'(WREADY), 64'd0);
            checkOutput("wfirst.awready", 64'(AWREADY), 64'd1);
            checkOutput("wfirst.request", 64'(write_request_o), 64'd0);
            if (i < 4) tick();
        end
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 32'hFFFF_0000, 4'hC, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("wfirst.request1", 64'(write_request_o), 64'd1);
        checkOutput("wfirst.address1", 64'(write_address_o), 64'h1004);
        checkOutput("wfirst.data1", 64'(write_data_o), 64'h1234_5678);
        checkOutput("wfirst.strobe1", 64'(write_strobe_o), 64'h3);
        tick();
        // Error without done must be ignored
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("wfirst.errnodone", 64'(BVALID), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("wfirst.bvalid", 64'(BVALID), 64'd1);
        checkOutput("wfirst.bresp", 64'(BRESP), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Address window boundaries
        doNoAccess("decerr_hi", 32'h0000_2000, 4'hF, 2'b11);
        doNoAccess("decerr_lo", 32'h0000_0FFF, 4'hF, 2'b11);
        doWrite("edge_hi", 32'h0000_1FFC, 32'h0102_0304, 4'h8, 1'b0, 2'b00);

        // Peripheral error and empty strobe
        doWrite("slverr", 32'h0000_1010, 32'h7777_8888, 4'hF, 1'b1, 2'b10);
        doNoAccess("nostrb", 32'h0000_1100, 4'h0, 2'b00);

        // BREADY held low with a second request waiting
        applyStimulus(1'b1, 32'h0000_1200, 1'b1, 32'hAAAA_5555, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h0000_1300, 1'b1, 32'h0BAD_F00D, 4'h5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall.bvalid", 64'(BVALID), 64'd1);
            checkOutput("stall.bresp", 64'(BRESP), 64'd2);
            checkOutput("stall.awready", 64'(AWREADY), 64'd0);
            checkOutput("stall.wready", 64'(WREADY), 64'd0);
            checkOutput("stall.address", 64'(write_address_o), 64'h1200);
            tick();
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        checkOutput("stall.release_bvalid", 64'(BVALID), 64'd0);
        checkOutput("stall.release_awready", 64'(AWREADY), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("stall.second_request", 64'(write_request_o), 64'd1);
        checkOutput("stall.second_address", 64'(write_address_o), 64'h1300);
        checkOutput("stall.second_data", 64'(write_data_o), 64'h0BAD_F00D);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("stall.second_bresp", 64'(BRESP), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Reset while waiting in WRITE
        applyStimulus(1'b1, 32'h0000_1400, 1'b1, 32'h4444_3333, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rstmid.request", 64'(write_request_o), 64'd1);
        tick();
        rst_i = 1'b1;
        tick();
        checkOutput("rstmid.bvalid", 64'(BVALID), 64'd0);
        checkOutput("rstmid.bresp", 64'(BRESP), 64'd0);
        checkOutput("rstmid.request", 64'(write_request_o), 64'd0);
        checkOutput("rstmid.awready", 64'(AWREADY), 64'd0);
        checkOutput("rstmid.wready", 64'(WREADY), 64'd0);
        checkOutput("rstmid.address", 64'(write_address_o), 64'd0);
        checkOutput("rstmid.data", 64'(write_data_o), 64'd0);
        checkOutput("rstmid.strobe", 64'(write_strobe_o), 64'd0);
        rst_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rstmid.late_done_bvalid", 64'(BVALID), 64'd0);
        tick();
        checkOutput("rstmid.late_done_bvalid2", 64'(BVALID), 64'd0);
        checkOutput("rstmid.awready_back", 64'(AWREADY), 64'd1);
        doWrite("after_rst", 32'h0000_1800, 32'h9876_5432, 4'hF, 1'b0, 2'b00);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_axi_write_slave_controller

// File: doc/axi_write_slave_controller.md
Name: axi_write_slave_controller

Overview:
AXI4-Lite write-path responder for ZenithSoC peripherals. It is the write-side counterpart of the read channel pair.
- Accepts the Write Address (AW) and Write Data (W) channels independently and in any order.
- Decodes the address against a window and issues one write to a simple peripheral register port.
- Returns the result on the Write Response (B) channel.
- One outstanding transaction at a time; no IDs, no bursts.

Parameters:
ADDR_LOW, 0, lowest accepted byte address (inclusive), width AXI_ADDR_SIZE
ADDR_HIGH, 32'hFFFF_FFFF, highest accepted byte address (inclusive)
Widths AXI_ADDR_SIZE (bits) and AXI_DATA_SIZE (bytes) and type axi_response_t come from axi_interface_pkg.

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous, active-high reset
AWADDR  in  AXI_ADDR_SIZE  write address
AWVALID  in  1  master address valid
AWREADY  out  1  slave can accept address
WDATA  in  AXI_DATA_SIZE x 8  write data, packed bytes
WSTRB  in  AXI_DATA_SIZE  byte enables
WVALID  in  1  master data valid
WREADY  out  1  slave can accept data
BRESP  out  axi_response_t  write response
BVALID  out  1  response valid
BREADY  in  1  master can accept response
write_address_o  out  AXI_ADDR_SIZE  captured address, stable from request to done
write_data_o  out  AXI_DATA_SIZE x 8  captured data
write_strobe_o  out  AXI_DATA_SIZE  captured strobes
write_request_o  out  1  single-cycle write request pulse
write_done_i  in  1  peripheral completed write
write_error_i  in  1  peripheral error, valid only with write_done_i

Behaviour:
- Reset (synchronous, rst_i=1 sampled on edge):
  - AWREADY=0, WREADY=0, BVALID=0, BRESP=OKAY (2'b00), write_request_o=0.
  - Captured address, data and strobe registers cleared to 0; both buffer-full flags cleared; FSM=IDLE.
  - Reset mid-transaction discards the pending write and drops BVALID immediately; no response is issued for it.
- Channel capture:
  - AWREADY = (state==IDLE) & !aw_full.
  - WREADY = (state==IDLE) & !w_full.
  - Both READYs are registered-state functions only and never depend combinationally on VALID.
  - AW handshake (AWVALID&AWREADY) latches AWADDR and sets aw_full.
  - W handshake latches WDATA/WSTRB and sets w_full.
  - AW and W may complete in the same cycle or in either order, with any gap between them.
- FSM states IDLE, WRITE, RESPOND:
  - IDLE: when aw_full & w_full (registered), evaluate the request and leave IDLE:
    - Address outside [ADDR_LOW, ADDR_HIGH]: go to RESPOND with BRESP=DECERR (2'b11); no peripheral access.
    - WSTRB all zero: go to RESPOND with BRESP=OKAY; no peripheral access.
    - Otherwise: assert write_request_o for exactly one cycle and go to WRITE.
  - WRITE: wait for write_done_i. write_done_i is sampled starting the cycle after the request pulse. On done, go to RESPOND with BRESP = write_error_i ? SLVERR (2'b10) : OKAY. Unbounded wait, no timeout.
  - RESPOND:
    - BVALID=1; BRESP stable while BVALID is high.
    - On BVALID&BREADY: BVALID=0, clear aw_full and w_full, go to IDLE.
    - BREADY held low stalls the block indefinitely.
- Latency: AW and W handshake in cycle 0 → buffers full in cycle 1 → write_request_o in cycle 1 → earliest done in cycle 2 → BVALID in cycle 3.
- Back-to-back: READYs reassert the cycle after the B handshake, so the minimum spacing between consecutive AW handshakes is 4 cycles.
- write_address_o, write_data_o and write_strobe_o are driven directly from the capture registers and hold their values until the next capture.
- write_done_i outside WRITE is ignored. write_error_i is ignored without write_done_i.

Test Plan:
- AW (0x1000) and W (0xDEADBEEF, strobe 4'hF) in the same cycle, done one cycle after the request → request pulse in cycle 1, output regs hold 0x1000/0xDEADBEEF/4'hF, BVALID in cycle 3 with OKAY, READYs high again after BREADY.
- W arrives 5 cycles before AW → WREADY=0 after the W handshake, AWREADY stays 1 until AW; request fires the cycle after AW captures, data unchanged.
- ADDR_LOW=0x1000, ADDR_HIGH=0x1FFF, AWADDR=0x2000 → write_request_o never asserts, BVALID with DECERR; AWADDR=0x1FFC → normal write.
- write_done_i=1 with write_error_i=1 → BRESP=SLVERR. Separately, WSTRB=4'h0 → no request, OKAY.
- BREADY held low 10 cycles → BVALID and BRESP stable, AWREADY=WREADY=0 throughout, second AW/W stalled until the B handshake.
- rst_i asserted while in WRITE (done not yet seen) → next cycle all outputs at reset values; a later write_done_i is ignored; the next transaction completes normally with OKAY.
